comparison_unit_rv32i: RTL and testbench

//  Branch-condition evaluator for the RV32I core (execute stage).
//  - Compares two 32-bit register operands under a 3-bit condition code.
//  - Raises approved when the branch is taken.
//  - Result is available combinationally, for same-cycle redirect, and as a registered copy for the pipeline.

---
 rtl/rv32i_pkg.sv | 18 +
 rtl/rv32i_cmp_core.sv | 28 ++
 rtl/comparison_unit_rv32i.sv | 64 ++++++
 tb/tb_comparison_unit_rv32i.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared types for the RV32I branch comparison unit.
// Condition codes and operand width.
package rv32i_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        CMP_EQ   = 3'b000,
        CMP_NE   = 3'b001,
        CMP_NEA  = 3'b010,
        CMP_NONE = 3'b011,
        CMP_LT   = 3'b100,
        CMP_GE   = 3'b101,
        CMP_LTU  = 3'b110,
        CMP_GEU  = 3'b111
    } cmp_cond_e;

endpackage

// File: rtl/rv32i_cmp_core.sv
// Combinational compare core: equality, signed and unsigned less-than.
// Ordering comes from 33-bit extended differences, equality from XOR.
module rv32i_cmp_core
    import rv32i_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            eq,
    output logic            lt_s,
    output logic            lt_u
);

    logic [XLEN:0] diff_s;
    logic [XLEN:0] diff_u;
    logic          unused_low;

    // Extended subtraction cannot overflow, so bit XLEN is the ordering.
    always_comb begin
        diff_s = {a[XLEN-1], a} - {b[XLEN-1], b};
        diff_u = {1'b0, a} - {1'b0, b};
        eq     = ~|(a ^ b);
        lt_s   = diff_s[XLEN];
        lt_u   = diff_u[XLEN];
    end

    assign unused_low = ^{diff_s[XLEN-1:0], diff_u[XLEN-1:0]};

endmodule

// File: rtl/comparison_unit_rv32i.sv
// Branch-condition evaluator for the execute stage.
// Combinational taken result plus a one-cycle registered copy.
module comparison_unit_rv32i
    import rv32i_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      cond,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            valid_in,
    output logic            approved,
    output logic            approved_q,
    output logic            valid_q
);

    logic eq;
    logic lt_s;
    logic lt_u;
    logic approved_d;
    logic valid_d;

    rv32i_cmp_core u_core (
        .a    (a),
        .b    (b),
        .eq   (eq),
        .lt_s (lt_s),
        .lt_u (lt_u)
    );

    // Select the taken result for the current condition code.
    always_comb begin
        approved = 1'b0;
        case (cmp_cond_e'(cond))
            CMP_EQ:   approved = eq;
            CMP_NE:   approved = ~eq;
            CMP_NEA:  approved = ~eq;
            CMP_NONE: approved = 1'b0;
            CMP_LT:   approved = lt_s;
            CMP_GE:   approved = ~lt_s;
            CMP_LTU:  approved = lt_u;
            CMP_GEU:  approved = ~lt_u;
            default:  approved = 1'b0;
        endcase
    end

    // Only real branches may produce a registered taken result.
    always_comb begin
        valid_d    = valid_in;
        approved_d = valid_in & approved;
    end

    // Pipeline register; reset discards any in-flight result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            approved_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            approved_q <= approved_d;
        end
    end

endmodule

// File: tb/tb_comparison_unit_rv32i.sv
// Self-checking bench for comparison_unit_rv32i.
// Expected results are queued at drive time and popped at check time.
module tb_comparison_unit_rv32i;

    logic        clk;
    logic        rst;
    logic [2:0]  cond;
    logic [31:0] a;
    logic [31:0] b;
    logic        valid_in;
    logic        approved;
    logic        approved_q;
    logic        valid_q;

    int vectors;
    int miscompares;

    logic       cq[$];
    logic [1:0] rq[$];

    comparison_unit_rv32i dut (
        .clk        (clk),
        .rst        (rst),
        .cond       (cond),
        .a          (a),
        .b          (b),
        .valid_in   (valid_in),
        .approved   (approved),
        .approved_q (approved_q),
        .valid_q    (valid_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model(input logic [2:0] c,
                                   input logic [31:0] x,
                                   input logic [31:0] y);
        case (c)
            3'd0:    return x == y;
            3'd1:    return x != y;
            3'd2:    return x != y;
            3'd3:    return 1'b0;
            3'd4:    return $signed(x) < $signed(y);
            3'd5:    return $signed(x) >= $signed(y);
            3'd6:    return x < y;
            default: return x >= y;
        endcase
    endfunction

    task automatic check_bit(input string tag, input logic obs,
                             input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic comb(input string tag, input logic [2:0] c,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic exp);
        logic e;
        cond = c;
        a    = x;
        b    = y;
        cq.push_back(exp);
        #1;
        if (cq.size() == 0) begin
            check_bit({tag, "_empty"}, 1'b1, 1'b0);
        end else begin
            e = cq.pop_front();
            check_bit(tag, approved, e);
        end
    endtask

    task automatic reg_step(input string tag, input logic v,
                            input logic [2:0] c, input logic [31:0] x,
                            input logic [31:0] y);
        logic [1:0] e;
        @(negedge clk);
        valid_in = v;
        cond     = c;
        a        = x;
        b        = y;
        rq.push_back({v, v & model(c, x, y)});
        @(posedge clk);
        #1;
        e = rq.pop_front();
        check_bit({tag, "_vq"}, valid_q, e[1]);
        check_bit({tag, "_aq"}, approved_q, e[0]);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        valid_in    = 1'b0;
        cond        = 3'd0;
        a           = '0;
        b           = '0;

        #1;
        check_bit("rst_vq", valid_q, 1'b0);
        check_bit("rst_aq", approved_q, 1'b0);
        @(posedge clk);
        #1;
        check_bit("rst_hold_vq", valid_q, 1'b0);
        check_bit("rst_hold_aq", approved_q, 1'b0);

        // Combinational directed vectors
        comb("eq_zero",   3'b000, 32'd0, 32'd0, 1'b1);
        comb("ne_alias",  3'b010, 32'd1, 32'd2, 1'b1);
        comb("eq_diff",   3'b000, 32'd1, 32'd2, 1'b0);
        comb("ne_plain",  3'b001, 32'd1, 32'd2, 1'b1);
        comb("lt_pos",    3'b100, 32'd1, 32'd2, 1'b1);
        comb("lt_neg",    3'b100, 32'hFFFF_FFFF, 32'd1, 1'b1);
        comb("ltu_big",   3'b110, 32'hFFFF_FFFF, 32'd1, 1'b0);
        comb("geu_big",   3'b111, 32'hFFFF_FFFF, 32'd1, 1'b1);
        comb("ge_eq5",    3'b101, 32'd5, 32'd5, 1'b1);
        comb("never",     3'b011, 32'd5, 32'd5, 1'b0);
        comb("never2",    3'b011, 32'h1234, 32'h99, 1'b0);
        comb("lt_b31",    3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        comb("ge_b31",    3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
        comb("ltu_b31",   3'b110, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
        comb("geu_b31",   3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        comb("lt_b31r",   3'b100, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
        comb("ltu_b31r",  3'b110, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        comb("aeqb_ne",   3'b001, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        comb("aeqb_lt",   3'b100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        comb("aeqb_ltu",  3'b110, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        comb("aeqb_geu",  3'b111, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
        comb("eq_hibit",  3'b000, 32'h8000_0000, 32'h0000_0000, 1'b0);

        for (int i = 0; i < 24; i++) begin
            logic [2:0]  c;
            logic [31:0] x;
            logic [31:0] y;
            c = 3'($urandom_range(0, 7));
            x = $urandom;
            y = (i % 4 == 0) ? x : $urandom;
            comb("rand", c, x, y, model(c, x, y));
        end

        // Release reset between edges; first capture on next posedge
        @(negedge clk);
        rst = 1'b0;
        reg_step("first", 1'b1, 3'b000, 32'd7, 32'd7);
        reg_step("inval", 1'b0, 3'b000, 32'd7, 32'd7);
        reg_step("nt",    1'b1, 3'b001, 32'd7, 32'd7);
        reg_step("lt",    1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1);
        reg_step("inv2",  1'b0, 3'b110, 32'd1, 32'd2);
        reg_step("eq7",   1'b1, 3'b000, 32'd7, 32'd7);

        // Asynchronous reset pulse between edges
        rst = 1'b1;
        #1;
        check_bit("arst_vq", valid_q, 1'b0);
        check_bit("arst_aq", approved_q, 1'b0);
        rst = 1'b0;
        #1;
        check_bit("arst_rel_vq", valid_q, 1'b0);
        check_bit("arst_rel_aq", approved_q, 1'b0);

        for (int i = 0; i < 12; i++) begin
            logic [2:0]  c;
            logic [31:0] x;
            c = 3'($urandom_range(0, 7));
            x = $urandom;
            reg_step("rstream", 1'($urandom_range(0, 1)), c, x,
                     (i % 3 == 0) ? x : $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
